// File: rtl/nnue_pkg.sv
// Shared types and helpers for the NNUE feature-update sequencer.
// Feature rows are {piece_type, square}; results are 16-bit signed.
package nnue_pkg;

  localparam int ROW_W = 7;
  localparam int SQ_W  = 6;
  localparam int RES_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  typedef struct packed {
    logic            player;
    logic            piece;
    logic [SQ_W-1:0] from_sq;
    logic [SQ_W-1:0] to_sq;
    logic            cap;
    logic            cap_piece;
  } move_t;

  typedef struct packed {
    logic             add;
    logic [ROW_W-1:0] row;
  } op_t;

  function automatic logic [ROW_W-1:0] row_encode(input logic piece, input logic [SQ_W-1:0] sq);
    return {piece, sq};
  endfunction

endpackage

// File: rtl/nnue_feature_sequencer_if.sv
// Move-descriptor handshake, accumulator command bus and result/status signals.
// master = environment (move source + accumulator), slave = sequencer.
interface nnue_feature_sequencer_if;
  import nnue_pkg::*;

  logic                    mv_valid;
  logic                    mv_ready;
  logic                    mv_player;
  logic                    mv_piece;
  logic [SQ_W-1:0]         mv_from;
  logic [SQ_W-1:0]         mv_to;
  logic                    mv_cap;
  logic                    mv_cap_piece;

  logic                    nn_trigger;
  logic                    nn_player;
  logic [ROW_W-1:0]        nn_row;
  logic                    nn_add;
  logic                    nn_finish;
  logic signed [RES_W-1:0] nn_out;

  logic signed [RES_W-1:0] eval;
  logic                    eval_valid;
  logic                    err;
  logic                    busy;

  modport master (
    output mv_valid, mv_player, mv_piece, mv_from, mv_to, mv_cap, mv_cap_piece,
    output nn_finish, nn_out,
    input  mv_ready, nn_trigger, nn_player, nn_row, nn_add,
    input  eval, eval_valid, err, busy
  );

  modport slave (
    input  mv_valid, mv_player, mv_piece, mv_from, mv_to, mv_cap, mv_cap_piece,
    input  nn_finish, nn_out,
    output mv_ready, nn_trigger, nn_player, nn_row, nn_add,
    output eval, eval_valid, err, busy
  );

endinterface

// File: rtl/nnue_watchdog.sv
// Per-operation timeout counter: cleared at issue, counts wait cycles,
// flags expire during the TIMEOUT-th wait cycle.
module nnue_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [7:0] cnt;

  assign expire = en && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/nnue_feature_sequencer.sv
// Turns one chess move into 2 (quiet) or 3 (capture) accumulator row updates,
// issued one at a time, and captures the final accumulator result.
module nnue_feature_sequencer
  import nnue_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int OP_GAP  = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  nnue_feature_sequencer_if.slave bus
);

  localparam logic [1:0] GAP_LAST = 2'((OP_GAP > 0) ? OP_GAP - 1 : 0);

  state_t                  state_q, state_d;
  move_t                   mv_in, mv_q, op_src;
  op_t                     op_next;
  logic [1:0]              op_idx_q, op_sel, num_ops, gap_cnt_q;
  logic                    load_op, last_op, expire;
  logic                    nn_player_q, nn_add_q, err_q;
  logic [ROW_W-1:0]        nn_row_q;
  logic signed [RES_W-1:0] eval_q;

  function automatic op_t op_decode(input move_t m, input logic [1:0] idx);
    op_t o;
    o.add = 1'b1;
    o.row = row_encode(m.piece, m.to_sq);
    if (idx == 2'd0) begin
      o.add = 1'b0;
      o.row = row_encode(m.piece, m.from_sq);
    end else if (idx == 2'd1 && m.cap) begin
      o.add = 1'b0;
      o.row = row_encode(m.cap_piece, m.to_sq);
    end
    return o;
  endfunction

  assign mv_in = '{player: bus.mv_player, piece: bus.mv_piece, from_sq: bus.mv_from,
                   to_sq: bus.mv_to, cap: bus.mv_cap, cap_piece: bus.mv_cap_piece};

  // In IDLE the first op is built straight from the incoming move so it is
  // ready on the bus in the ISSUE cycle; later ops come from the latched copy.
  assign op_src  = (state_q == S_IDLE) ? mv_in : mv_q;
  assign op_sel  = (state_q == S_IDLE) ? 2'd0 : op_idx_q;
  assign op_next = op_decode(op_src, op_sel);
  assign num_ops = mv_q.cap ? 2'd3 : 2'd2;
  assign last_op = (op_idx_q == num_ops);
  assign load_op = (state_d == S_ISSUE) && (state_q != S_ISSUE);

  nnue_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q == S_ISSUE),
    .en     (state_q == S_WAIT),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.mv_valid) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.nn_finish) begin
          if (last_op)          state_d = S_DONE;
          else if (OP_GAP == 0) state_d = S_ISSUE;
          else                  state_d = S_GAP;
        end else if (expire) begin
          state_d = S_IDLE;
        end
      end
      S_GAP:   if (gap_cnt_q == GAP_LAST) state_d = S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mv_q        <= '0;
      op_idx_q    <= '0;
      gap_cnt_q   <= '0;
      nn_player_q <= 1'b0;
      nn_add_q    <= 1'b0;
      nn_row_q    <= '0;
      eval_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.mv_valid) mv_q <= mv_in;
      if (state_q == S_IDLE)       op_idx_q <= '0;
      else if (state_q == S_ISSUE) op_idx_q <= op_idx_q + 2'd1;
      gap_cnt_q <= (state_q == S_GAP) ? gap_cnt_q + 2'd1 : 2'd0;
      if (load_op) begin
        nn_player_q <= op_src.player;
        nn_add_q    <= op_next.add;
        nn_row_q    <= op_next.row;
      end
      if (state_q == S_WAIT && bus.nn_finish && last_op) eval_q <= bus.nn_out;
      if (state_q == S_WAIT && !bus.nn_finish && expire) err_q <= 1'b1;
    end
  end

  assign bus.mv_ready   = (state_q == S_IDLE);
  assign bus.nn_trigger = (state_q == S_ISSUE);
  assign bus.nn_player  = nn_player_q;
  assign bus.nn_add     = nn_add_q;
  assign bus.nn_row     = nn_row_q;
  assign bus.eval       = eval_q;
  assign bus.eval_valid = (state_q == S_DONE);
  assign bus.err        = err_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_nnue_feature_sequencer.sv
// Directed bench for nnue_feature_sequencer with TIMEOUT=8, OP_GAP=1; the
// accumulator answers 3 cycles after each trigger unless a step says otherwise.
module tb_nnue_feature_sequencer;
  import nnue_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   trig_cnt = 0;
  int   ev_cnt = 0;

  nnue_feature_sequencer_if bus();

  nnue_feature_sequencer #(.TIMEOUT(8), .OP_GAP(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.nn_trigger) trig_cnt <= trig_cnt + 1;
    if (bus.eval_valid) ev_cnt <= ev_cnt + 1;
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_move(input string tag, input logic player, input logic piece,
                            input int from_sq, input int to_sq, input logic cap,
                            input logic cap_piece, output int c0);
    check({tag, "_ready"}, bus.mv_ready, 1);
    bus.mv_player    = player;
    bus.mv_piece     = piece;
    bus.mv_from      = 6'(from_sq);
    bus.mv_to        = 6'(to_sq);
    bus.mv_cap       = cap;
    bus.mv_cap_piece = cap_piece;
    bus.mv_valid     = 1'b1;
    c0 = cyc;
  endtask

  task automatic wait_trig(input string tag);
    int n = 0;
    while (!bus.nn_trigger && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_trig"}, bus.nn_trigger, 1);
  endtask

  task automatic do_op(input string tag, input int row, input logic add, input logic player,
                       input int out_val, input bit spur);
    wait_trig(tag);
    check({tag, "_row"}, bus.nn_row, row);
    check({tag, "_add"}, bus.nn_add, add);
    check({tag, "_player"}, bus.nn_player, player);
    if (spur) begin
      bus.nn_finish = 1'b1;
      bus.nn_out    = 16'sd999;
      @(negedge clk);
      bus.nn_finish = 1'b0;
      check({tag, "_spur_busy"}, bus.busy, 1);
      repeat (2) @(negedge clk);
    end else begin
      repeat (3) @(negedge clk);
    end
    check({tag, "_hold"}, bus.nn_row, row);
    bus.nn_finish = 1'b1;
    bus.nn_out    = 16'(out_val);
    @(negedge clk);
    bus.nn_finish = 1'b0;
  endtask

  task automatic end_move(input string tag, input int exp_eval, input int c0, input int exp_lat);
    check({tag, "_evalid"}, bus.eval_valid, 1);
    check({tag, "_eval"}, bus.eval, exp_eval);
    check({tag, "_latency"}, cyc - c0, exp_lat);
    @(negedge clk);
    check({tag, "_evalid_off"}, bus.eval_valid, 0);
    check({tag, "_ready_after"}, bus.mv_ready, 1);
  endtask

  initial begin
    int c0, c1, t0, e0;
    bus.mv_valid = 0; bus.mv_player = 0; bus.mv_piece = 0; bus.mv_from = 0;
    bus.mv_to = 0; bus.mv_cap = 0; bus.mv_cap_piece = 0;
    bus.nn_finish = 0; bus.nn_out = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_trigger", bus.nn_trigger, 0);
    check("rst_row", bus.nn_row, 0);
    check("rst_add", bus.nn_add, 0);
    check("rst_player", bus.nn_player, 0);
    check("rst_eval", bus.eval, 0);
    check("rst_evalid", bus.eval_valid, 0);
    check("rst_err", bus.err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.mv_ready, 1);
    rst_n = 1'b1;

    // Quiet move: rows 12 rm, 28 add; latency 4+4+1+1
    t0 = trig_cnt; e0 = ev_cnt;
    start_move("q", 1, 0, 12, 28, 0, 0, c0);
    do_op("q_op0", 12, 0, 1, 0, 0);
    bus.mv_valid = 0;
    do_op("q_op1", 28, 1, 1, 250, 0);
    end_move("q", 250, c0, 10);
    check("q_trig_count", trig_cnt - t0, 2);
    check("q_eval_pulses", ev_cnt - e0, 1);

    // Capture: rows 69 rm, 20 rm, 84 add; latency 3*4+2+1
    t0 = trig_cnt;
    start_move("c", 0, 1, 5, 20, 1, 0, c0);
    do_op("c_op0", 69, 0, 0, 0, 0);
    bus.mv_valid = 0;
    do_op("c_op1", 20, 0, 0, 0, 0);
    do_op("c_op2", 84, 1, 0, 33, 0);
    end_move("c", 33, c0, 15);
    check("c_trig_count", trig_cnt - t0, 3);

    // Spurious finish in IDLE and in ISSUE
    e0 = ev_cnt;
    bus.nn_finish = 1'b1; bus.nn_out = 16'sd555;
    @(negedge clk);
    bus.nn_finish = 1'b0;
    check("sp_idle_busy", bus.busy, 0);
    check("sp_idle_evalid", ev_cnt - e0, 0);
    check("sp_idle_eval", bus.eval, 33);
    start_move("sp", 0, 1, 0, 63, 0, 0, c0);
    do_op("sp_op0", 64, 0, 0, 0, 1);
    bus.mv_valid = 0;
    do_op("sp_op1", 127, 1, 0, -5, 0);
    end_move("sp", -5, c0, 10);

    // Back-to-back with mv_valid held; second move has from == to
    start_move("bb1", 1, 0, 1, 2, 0, 0, c0);
    do_op("bb1_op0", 1, 0, 1, 0, 0);
    bus.mv_player = 0; bus.mv_piece = 1; bus.mv_from = 6'd3; bus.mv_to = 6'd3;
    check("bb1_ready_busy", bus.mv_ready, 0);
    do_op("bb1_op1", 2, 1, 1, -100, 0);
    end_move("bb1", -100, c0, 10);
    c1 = cyc;
    do_op("bb2_op0", 67, 0, 0, 0, 0);
    bus.mv_valid = 0;
    do_op("bb2_op1", 67, 1, 0, 7, 0);
    end_move("bb2", 7, c1, 10);

    // Timeout: no finish, 8 WAIT cycles then back to IDLE with err
    t0 = trig_cnt; e0 = ev_cnt;
    start_move("to", 0, 0, 10, 11, 0, 0, c0);
    wait_trig("to");
    bus.mv_valid = 0;
    repeat (8) @(negedge clk);
    check("to_err_before", bus.err, 0);
    check("to_busy_before", bus.busy, 1);
    @(negedge clk);
    check("to_err", bus.err, 1);
    check("to_busy", bus.busy, 0);
    check("to_ready", bus.mv_ready, 1);
    check("to_trig_count", trig_cnt - t0, 1);
    check("to_no_evalid", ev_cnt - e0, 0);
    check("to_eval_hold", bus.eval, 7);

    // err is sticky and moves are still accepted
    start_move("st", 1, 1, 7, 9, 0, 0, c0);
    do_op("st_op0", 71, 0, 1, 0, 0);
    bus.mv_valid = 0;
    do_op("st_op1", 73, 1, 1, 42, 0);
    end_move("st", 42, c0, 10);
    check("st_err_sticky", bus.err, 1);

    // Reset during WAIT of the second op
    start_move("rm", 1, 0, 20, 30, 0, 0, c0);
    do_op("rm_op0", 20, 0, 1, 0, 0);
    bus.mv_valid = 0;
    wait_trig("rm_op1");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rm_trigger", bus.nn_trigger, 0);
    check("rm_row", bus.nn_row, 0);
    check("rm_add", bus.nn_add, 0);
    check("rm_player", bus.nn_player, 0);
    check("rm_eval", bus.eval, 0);
    check("rm_evalid", bus.eval_valid, 0);
    check("rm_err", bus.err, 0);
    check("rm_busy", bus.busy, 0);
    check("rm_ready", bus.mv_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    start_move("ra", 1, 0, 12, 28, 0, 0, c0);
    do_op("ra_op0", 12, 0, 1, 0, 0);
    bus.mv_valid = 0;
    do_op("ra_op1", 28, 1, 1, 250, 0);
    end_move("ra", 250, c0, 10);
    check("ra_err", bus.err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
